// File: rtl/grf_write_arbiter.sv
// Shares the GRF write port between the W stage (zero latency) and a DEPTH-entry MDU result FIFO.
// Optional starvation relief is enabled by defining GRF_ARB_STARVE_EN.
module grf_write_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_we,
    input  logic [4:0]  wb_adr,
    input  logic [31:0] wb_wd,
    input  logic [31:0] wb_pc,
    output logic        wb_stall,
    input  logic        mdu_valid,
    input  logic [4:0]  mdu_adr,
    input  logic [31:0] mdu_wd,
    input  logic [31:0] mdu_pc,
    output logic        mdu_ready,
    input  logic [4:0]  q_adr1,
    input  logic [4:0]  q_adr2,
    output logic        q_busy1,
    output logic        q_busy2,
    output logic [4:0]  grf_adr,
    output logic [31:0] grf_wd,
    output logic [31:0] grf_pc
);
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PEND  = 2'd1;
    localparam logic [1:0] S_FORCE = 2'd2;

    logic [DEPTH-1:0]  valid_reg, valid_next;
    logic [4:0]        adr_reg [DEPTH];
    logic [31:0]       wd_reg  [DEPTH];
    logic [31:0]       pc_reg  [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_reg, wr_ptr_reg;
    logic [CNT_W-1:0]  count_reg, count_next;
    logic [WAIT_W-1:0] wait_reg, wait_next;
    logic [1:0]        state_reg, state_next;

    logic             w_grant, pop, m_grant, enq;
    logic [DEPTH-1:0] waw_hit, hit1, hit2;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_match
            assign waw_hit[gi] = valid_reg[gi] && (adr_reg[gi] == wb_adr);
            assign hit1[gi]    = valid_reg[gi] && (adr_reg[gi] == q_adr1);
            assign hit2[gi]    = valid_reg[gi] && (adr_reg[gi] == q_adr2);
        end
    endgenerate

    assign mdu_ready = !reset && (count_reg < CNT_W'(DEPTH));
    assign enq       = mdu_ready && mdu_valid && (mdu_adr != 5'd0);
    assign w_grant   = !reset && (state_reg != S_FORCE) && wb_we && (wb_adr != 5'd0);
    // Any non-W cycle with a non-empty FIFO pops the head; an invalidated head pops without a write.
    assign pop       = !reset && !w_grant && (count_reg != '0);
    assign m_grant   = pop && valid_reg[rd_ptr_reg];

    assign q_busy1 = !reset && (q_adr1 != 5'd0) && (|hit1);
    assign q_busy2 = !reset && (q_adr2 != 5'd0) && (|hit2);

`ifdef GRF_ARB_STARVE_EN
    assign wb_stall = !reset && (state_reg == S_FORCE);
`else
    assign wb_stall = 1'b0;
`endif

    always_comb begin
        grf_adr = 5'd0;
        grf_wd  = 32'd0;
        grf_pc  = 32'd0;
        if (w_grant) begin
            grf_adr = wb_adr;
            grf_wd  = wb_wd;
            grf_pc  = wb_pc;
        end else if (m_grant) begin
            grf_adr = adr_reg[rd_ptr_reg];
            grf_wd  = wd_reg[rd_ptr_reg];
            grf_pc  = pc_reg[rd_ptr_reg];
        end
    end

    // Same-cycle enqueue lands after the WAW clear, so the younger entry survives.
    always_comb begin
        valid_next = valid_reg;
        if (w_grant)
            valid_next = valid_next & ~waw_hit;
        if (pop)
            valid_next[rd_ptr_reg] = 1'b0;
        if (enq)
            valid_next[wr_ptr_reg] = 1'b1;
    end

    always_comb begin
        count_next = count_reg + CNT_W'(enq) - CNT_W'(pop);
        wait_next  = wait_reg;
        if (pop || (state_reg == S_IDLE))
            wait_next = '0;
        else if ((state_reg == S_PEND) && (wait_reg != WAIT_W'(STARVE_LIMIT)))
            wait_next = wait_reg + 1'b1;

        state_next = (count_next != '0) ? S_PEND : S_IDLE;
`ifdef GRF_ARB_STARVE_EN
        if ((state_reg == S_PEND) && !pop && (wait_next == WAIT_W'(STARVE_LIMIT)))
            state_next = S_FORCE;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_reg  <= '0;
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
            wait_reg   <= '0;
            state_reg  <= S_IDLE;
        end else begin
            valid_reg <= valid_next;
            count_reg <= count_next;
            wait_reg  <= wait_next;
            state_reg <= state_next;
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if (enq)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            adr_reg[wr_ptr_reg] <= mdu_adr;
            wd_reg[wr_ptr_reg]  <= mdu_wd;
            pc_reg[wr_ptr_reg]  <= mdu_pc;
        end
    end

endmodule

// File: tb/tb_grf_write_arbiter.sv
// Directed self-checking bench for grf_write_arbiter (DEPTH=2, STARVE_LIMIT=4).
module tb_grf_write_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        wb_we;
    logic [4:0]  wb_adr;
    logic [31:0] wb_wd, wb_pc;
    logic        wb_stall;
    logic        mdu_valid;
    logic [4:0]  mdu_adr;
    logic [31:0] mdu_wd, mdu_pc;
    logic        mdu_ready;
    logic [4:0]  q_adr1, q_adr2;
    logic        q_busy1, q_busy2;
    logic [4:0]  grf_adr;
    logic [31:0] grf_wd, grf_pc;

    int errors = 0;
    int checks = 0;

    logic [31:0] grf_mem [32];
    logic        seen_bad = 1'b0;

    always #5 clk = ~clk;

    grf_write_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .wb_we(wb_we), .wb_adr(wb_adr), .wb_wd(wb_wd), .wb_pc(wb_pc), .wb_stall(wb_stall),
        .mdu_valid(mdu_valid), .mdu_adr(mdu_adr), .mdu_wd(mdu_wd), .mdu_pc(mdu_pc),
        .mdu_ready(mdu_ready),
        .q_adr1(q_adr1), .q_adr2(q_adr2), .q_busy1(q_busy1), .q_busy2(q_busy2),
        .grf_adr(grf_adr), .grf_wd(grf_wd), .grf_pc(grf_pc)
    );

    // Behavioural GRF: records every write the arbiter issues, sampled mid-cycle.
    initial for (int i = 0; i < 32; i++) grf_mem[i] = 32'd0;
    always @(negedge clk) begin
        if (!reset && grf_adr != 5'd0) begin
            grf_mem[grf_adr] = grf_wd;
            if (grf_adr == 5'd5 && grf_wd == 32'h1) seen_bad = 1'b1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        wb_we = 0; wb_adr = 0; wb_wd = 0; wb_pc = 0;
        mdu_valid = 0; mdu_adr = 0; mdu_wd = 0; mdu_pc = 0;
        q_adr1 = 0; q_adr2 = 0;
    endtask

    task automatic test_reset();
        reset = 1; idle_inputs();
        step(); step();
        wb_we = 1; wb_adr = 5'd8; wb_wd = 32'h77; mdu_valid = 1; mdu_adr = 5'd3;
        settle();
        checks++; if (grf_adr !== 5'd0) begin errors++; $display("FAIL rst_grf_adr: got %0d want 0", grf_adr); end
        checks++; if (mdu_ready !== 1'b0) begin errors++; $display("FAIL rst_mdu_ready: got %b want 0", mdu_ready); end
        checks++; if (wb_stall !== 1'b0) begin errors++; $display("FAIL rst_wb_stall: got %b want 0", wb_stall); end
        step();
        idle_inputs(); reset = 0;
        settle();
        checks++; if (mdu_ready !== 1'b1) begin errors++; $display("FAIL post_rst_ready: got %b want 1", mdu_ready); end
        checks++; if (grf_adr !== 5'd0) begin errors++; $display("FAIL post_rst_grf_adr: got %0d want 0", grf_adr); end
        $display("test_reset done");
    endtask

    task automatic test_pass_through();
        wb_we = 1; wb_adr = 5'd8; wb_wd = 32'h1234; wb_pc = 32'h3000;
        settle();
        checks++; if (grf_adr !== 5'd8) begin errors++; $display("FAIL pt_adr: got %0d want 8", grf_adr); end
        checks++; if (grf_wd !== 32'h1234) begin errors++; $display("FAIL pt_wd: got %h want 1234", grf_wd); end
        checks++; if (grf_pc !== 32'h3000) begin errors++; $display("FAIL pt_pc: got %h want 3000", grf_pc); end
        step();
        idle_inputs();
        $display("test_pass_through done");
    endtask

    task automatic test_mdu_single();
        mdu_valid = 1; mdu_adr = 5'd9; mdu_wd = 32'hAA; mdu_pc = 32'h4000; q_adr1 = 5'd9;
        settle();
        checks++; if (q_busy1 !== 1'b0) begin errors++; $display("FAIL mdu_busy_pre: got %b want 0", q_busy1); end
        checks++; if (grf_adr !== 5'd0) begin errors++; $display("FAIL mdu_no_bypass: got %0d want 0", grf_adr); end
        step();
        mdu_valid = 0;
        settle();
        checks++; if (q_busy1 !== 1'b1) begin errors++; $display("FAIL mdu_busy_n1: got %b want 1", q_busy1); end
        checks++; if (grf_adr !== 5'd9) begin errors++; $display("FAIL mdu_adr_n1: got %0d want 9", grf_adr); end
        checks++; if (grf_wd !== 32'hAA) begin errors++; $display("FAIL mdu_wd_n1: got %h want aa", grf_wd); end
        checks++; if (grf_pc !== 32'h4000) begin errors++; $display("FAIL mdu_pc_n1: got %h want 4000", grf_pc); end
        step();
        checks++; if (q_busy1 !== 1'b0) begin errors++; $display("FAIL mdu_busy_n2: got %b want 0", q_busy1); end
        checks++; if (grf_adr !== 5'd0) begin errors++; $display("FAIL mdu_adr_n2: got %0d want 0", grf_adr); end
        // Destination $0 is accepted but discarded: two of them must not fill the FIFO.
        mdu_valid = 1; mdu_adr = 5'd0; mdu_wd = 32'hDEAD;
        step(); step();
        mdu_valid = 0;
        settle();
        checks++; if (mdu_ready !== 1'b1) begin errors++; $display("FAIL zero_adr_ready: got %b want 1", mdu_ready); end
        checks++; if (grf_adr !== 5'd0) begin errors++; $display("FAIL zero_adr_write: got %0d want 0", grf_adr); end
        idle_inputs();
        $display("test_mdu_single done");
    endtask

    task automatic test_fifo_full();
        wb_we = 1; wb_adr = 5'd3; wb_wd = 32'h3;
        mdu_valid = 1; mdu_adr = 5'd10; mdu_wd = 32'h10; mdu_pc = 32'h100;
        settle();
        checks++; if (mdu_ready !== 1'b1) begin errors++; $display("FAIL full_ready_a: got %b want 1", mdu_ready); end
        step();
        mdu_adr = 5'd11; mdu_wd = 32'h11;
        settle();
        checks++; if (mdu_ready !== 1'b1) begin errors++; $display("FAIL full_ready_b: got %b want 1", mdu_ready); end
        step();
        mdu_adr = 5'd12; mdu_wd = 32'h12; q_adr1 = 5'd10; q_adr2 = 5'd11;
        settle();
        checks++; if (mdu_ready !== 1'b0) begin errors++; $display("FAIL full_ready_c: got %b want 0", mdu_ready); end
        checks++; if (grf_adr !== 5'd3) begin errors++; $display("FAIL full_w_wins: got %0d want 3", grf_adr); end
        checks++; if (q_busy1 !== 1'b1 || q_busy2 !== 1'b1) begin errors++; $display("FAIL full_busy: got %b%b want 11", q_busy1, q_busy2); end
        step();
        wb_we = 0;
        settle();
        checks++; if (mdu_ready !== 1'b0) begin errors++; $display("FAIL full_ready_d: got %b want 0", mdu_ready); end
        checks++; if (grf_adr !== 5'd10 || grf_wd !== 32'h10) begin errors++; $display("FAIL drain_0: got %0d/%h want 10/10", grf_adr, grf_wd); end
        step();
        settle();
        checks++; if (mdu_ready !== 1'b1) begin errors++; $display("FAIL full_ready_e: got %b want 1", mdu_ready); end
        checks++; if (grf_adr !== 5'd11 || grf_wd !== 32'h11) begin errors++; $display("FAIL drain_1: got %0d/%h want 11/11", grf_adr, grf_wd); end
        step();
        mdu_valid = 0;
        settle();
        checks++; if (grf_adr !== 5'd12 || grf_wd !== 32'h12) begin errors++; $display("FAIL drain_2: got %0d/%h want 12/12", grf_adr, grf_wd); end
        step();
        checks++; if (grf_adr !== 5'd0) begin errors++; $display("FAIL drain_empty: got %0d want 0", grf_adr); end
        idle_inputs();
        $display("test_fifo_full done");
    endtask

    task automatic test_waw();
        mdu_valid = 1; mdu_adr = 5'd5; mdu_wd = 32'h1; wb_we = 1; wb_adr = 5'd6; wb_wd = 32'h6;
        step();
        mdu_valid = 0; wb_adr = 5'd5; wb_wd = 32'h2; q_adr1 = 5'd5;
        settle();
        checks++; if (q_busy1 !== 1'b1) begin errors++; $display("FAIL waw_busy_pre: got %b want 1", q_busy1); end
        checks++; if (grf_adr !== 5'd5 || grf_wd !== 32'h2) begin errors++; $display("FAIL waw_w_write: got %0d/%h want 5/2", grf_adr, grf_wd); end
        step();
        wb_we = 0;
        settle();
        checks++; if (q_busy1 !== 1'b0) begin errors++; $display("FAIL waw_busy_post: got %b want 0", q_busy1); end
        checks++; if (grf_adr !== 5'd0) begin errors++; $display("FAIL waw_silent_pop: got %0d want 0", grf_adr); end
        step(); step();
        checks++; if (seen_bad !== 1'b0) begin errors++; $display("FAIL waw_stale_seen: got %b want 0", seen_bad); end
        checks++; if (grf_mem[5] !== 32'h2) begin errors++; $display("FAIL waw_final: got %h want 2", grf_mem[5]); end
        checks++; if (mdu_ready !== 1'b1) begin errors++; $display("FAIL waw_empty: got %b want 1", mdu_ready); end
        idle_inputs();
        $display("test_waw done");
    endtask

    task automatic test_starve();
        wb_we = 1; wb_adr = 5'd1; wb_wd = 32'h1;
        mdu_valid = 1; mdu_adr = 5'd20; mdu_wd = 32'h55; q_adr1 = 5'd20;
        step();
        mdu_valid = 0;
        for (int c = 1; c <= 4; c++) begin
            settle();
            checks++; if (grf_adr !== 5'd1 || wb_stall !== 1'b0) begin errors++; $display("FAIL starve_wait%0d: got adr=%0d stall=%b want adr=1 stall=0", c, grf_adr, wb_stall); end
            step();
        end
        settle();
`ifdef GRF_ARB_STARVE_EN
        checks++; if (wb_stall !== 1'b1) begin errors++; $display("FAIL starve_stall: got %b want 1", wb_stall); end
        checks++; if (grf_adr !== 5'd20 || grf_wd !== 32'h55) begin errors++; $display("FAIL starve_force: got %0d/%h want 20/55", grf_adr, grf_wd); end
        step();
        checks++; if (wb_stall !== 1'b0 || q_busy1 !== 1'b0) begin errors++; $display("FAIL starve_after: got stall=%b busy=%b want 0 0", wb_stall, q_busy1); end
        checks++; if (grf_adr !== 5'd1) begin errors++; $display("FAIL starve_w_resume: got %0d want 1", grf_adr); end
        step();
        wb_we = 0;
        settle();
        checks++; if (grf_adr !== 5'd0) begin errors++; $display("FAIL starve_empty: got %0d want 0", grf_adr); end
`else
        checks++; if (wb_stall !== 1'b0) begin errors++; $display("FAIL starve_stall: got %b want 0", wb_stall); end
        checks++; if (grf_adr !== 5'd1 || q_busy1 !== 1'b1) begin errors++; $display("FAIL starve_pending: got adr=%0d busy=%b want 1 1", grf_adr, q_busy1); end
        step(); step();
        checks++; if (q_busy1 !== 1'b1) begin errors++; $display("FAIL starve_still_pending: got %b want 1", q_busy1); end
        wb_we = 0;
        settle();
        checks++; if (grf_adr !== 5'd20 || grf_wd !== 32'h55) begin errors++; $display("FAIL starve_drain: got %0d/%h want 20/55", grf_adr, grf_wd); end
`endif
        step();
        idle_inputs();
        $display("test_starve done");
    endtask

    task automatic test_reset_flush();
        wb_we = 1; wb_adr = 5'd2; wb_wd = 32'h2;
        mdu_valid = 1; mdu_adr = 5'd21; mdu_wd = 32'h21;
        step();
        mdu_adr = 5'd22; mdu_wd = 32'h22;
        step();
        mdu_valid = 0; wb_we = 0; q_adr1 = 5'd21; q_adr2 = 5'd22; reset = 1;
        settle();
        checks++; if (grf_adr !== 5'd0) begin errors++; $display("FAIL flush_rst_adr: got %0d want 0", grf_adr); end
        checks++; if (mdu_ready !== 1'b0) begin errors++; $display("FAIL flush_rst_ready: got %b want 0", mdu_ready); end
        step();
        reset = 0;
        settle();
        checks++; if (q_busy1 !== 1'b0 || q_busy2 !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b%b want 00", q_busy1, q_busy2); end
        checks++; if (mdu_ready !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b want 1", mdu_ready); end
        for (int c = 0; c < 3; c++) begin
            checks++; if (grf_adr !== 5'd0) begin errors++; $display("FAIL flush_no_write%0d: got %0d want 0", c, grf_adr); end
            step();
        end
        idle_inputs();
        $display("test_reset_flush done");
    endtask

    initial begin
        test_reset();
        test_pass_through();
        test_mdu_single();
        test_fifo_full();
        test_waw();
        test_starve();
        test_reset_flush();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
